// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetcher: FSM states, FIFO entry layout, word size.
// Pure declarations, no timing or backpressure behaviour of its own.
package prefetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// ROM-side fetch bus: request/address out, same-cycle grant, in-order response one or more cycles later.
// No buffering; the ROM throttles by withholding instr_gnt_i.
interface instr_prefetch_buffer_if;

  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i
  );

endinterface

// File: rtl/instr_prefetch_buffer_fifo.sv
// Generic power-of-two FIFO with synchronous clear; head is read straight from storage.
// Push->head visible next cycle; push on full is accepted only alongside a pop.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with branch flush; PREFETCH_STATS_EN adds fetch/discard counters.
// Request->valid_o 2 cycles; ready_i low fills the FIFO and FIFO+in-flight credit then holds instr_req_o low.
module instr_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    branch_i,
  input  logic [31:0]             branch_addr_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             rdata_o,
  output logic [31:0]             addr_o,
  instr_prefetch_buffer_if.master rom
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]             stat_fetched_o,
  output logic [31:0]             stat_discarded_o
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [31:0]   inflight_q [MAX_OUTSTANDING];
  logic [31:0]   inflight_d [MAX_OUTSTANDING];
  logic [PW-1:0] infl_wr_q, infl_wr_d;
  logic [PW-1:0] infl_rd_q, infl_rd_d;

  logic          issue, accept, resp, push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   credit_used;
  fetch_entry_t  push_entry, head_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts buffered words plus responses that will actually be kept.
  assign credit_used = 32'(fifo_count) + 32'(outstanding_q) - 32'(discard_q);
  assign issue       = rst_ni & req_i & ~branch_i & (credit_used < 32'(DEPTH))
                     & (outstanding_q < OW'(MAX_OUTSTANDING));
  assign accept      = issue & rom.instr_gnt_i;
  assign resp        = rom.instr_rvalid_i & (outstanding_q != '0);
  assign push        = resp & (discard_q == '0) & ~branch_i;
  assign pop         = valid_o & ready_i & ~branch_i;

  assign rom.instr_req_o  = issue;
  assign rom.instr_addr_o = rst_ni ? fetch_addr_q : BOOT_ADDR;

  assign push_entry = '{addr: inflight_q[infl_rd_q], data: rom.instr_rdata_i};
  assign valid_o    = ~fifo_empty;
  assign addr_o     = head_entry.addr;
  assign rdata_o    = head_entry.data;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (branch_i),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .head_dat_o (head_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(resp);
    discard_d     = discard_q;
    inflight_d    = inflight_q;
    infl_wr_d     = infl_wr_q;
    infl_rd_d     = infl_rd_q;
    if (accept) begin
      inflight_d[infl_wr_q] = fetch_addr_q;
      infl_wr_d             = ptr_inc(infl_wr_q);
      fetch_addr_d          = fetch_addr_q + 32'(WORD_BYTES);
    end
    if (resp) begin
      infl_rd_d = ptr_inc(infl_rd_q);
    end
    // Everything still in flight after this cycle belongs to the old stream.
    if (branch_i) begin
      fetch_addr_d = word_align(branch_addr_i);
      discard_d    = outstanding_q - OW'(resp);
    end else if (resp && (discard_q != '0)) begin
      discard_d = discard_q - OW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) state_d = RUN;
      end
      RUN: begin
        if (branch_i && (outstanding_d != '0)) state_d = FLUSH;
        else if (!req_i)                       state_d = IDLE;
      end
      FLUSH: begin
        if (discard_d == '0) state_d = req_i ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      fetch_addr_q  <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
      infl_wr_q     <= '0;
      infl_rd_q     <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        inflight_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      infl_wr_q     <= infl_wr_d;
      infl_rd_q     <= infl_rd_d;
      inflight_q    <= inflight_d;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_discarded_q, stat_discarded_d;

  always_comb begin
    stat_fetched_d   = stat_fetched_q + 32'(push);
    stat_discarded_d = stat_discarded_q + 32'(resp & ~push)
                     + (branch_i ? 32'(fifo_count) : 32'd0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_d;
      stat_discarded_q <= stat_discarded_d;
    end
  end

  assign stat_fetched_o   = stat_fetched_q;
  assign stat_discarded_o = stat_discarded_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: queue-based reference model, directed scenarios, then random traffic.
module tb_instr_prefetch_buffer;
  import prefetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_ni, req_i, branch_i, ready_i, valid_o;
  logic [31:0] branch_addr_i, rdata_o, addr_o;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_o, stat_discarded_o;
`endif

  instr_prefetch_buffer_if rom_if ();

  instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .BOOT_ADDR(BOOT)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .rom           (rom_if)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetched_o   (stat_fetched_o),
    .stat_discarded_o (stat_discarded_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered entries, in-flight PCs with a stale flag, fetch pointer.
  fetch_entry_t m_fifo[$];
  logic [31:0]  m_infl[$];
  bit           m_stale[$];
  logic [31:0]  m_fetch;
  logic [31:0]  m_fetched, m_disc;
  logic [31:0]  rom_q[$];
  bit           rom_mode = 1'b0;

  bit          drv_rst = 1'b1, drv_req = 1'b0, drv_ready = 1'b0, drv_branch = 1'b0;
  bit          drv_gnt = 1'b1, drv_rv = 1'b1, drv_stray = 1'b0;
  logic [31:0] drv_baddr = '0;

  logic        s_req, s_valid;
  logic [31:0] s_iaddr, s_addr, s_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return rom_mode ? (a ^ 32'h5A5A_0000) : a;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_infl.delete();
    m_stale.delete();
    m_fetch   = BOOT;
    m_fetched = '0;
    m_disc    = '0;
  endtask

  // One clock: drive at negedge, compare against the model, update model at posedge.
  task automatic step();
    int          live;
    bit          exp_req, exp_valid, rv_now, rv_from_q;
    logic [31:0] exp_iaddr, rd_now, a;
    bit          st;
    fetch_entry_t e;
    @(negedge clk);
    rst_ni        = drv_rst;
    req_i         = drv_req;
    ready_i       = drv_ready;
    branch_i      = drv_branch;
    branch_addr_i = drv_baddr;
    rom_if.instr_gnt_i = drv_gnt;
    rv_from_q = 1'b0;
    if (drv_rv && rom_q.size() > 0) begin
      rv_now    = 1'b1;
      rv_from_q = 1'b1;
      rd_now    = rom_word(rom_q[0]);
    end else if (drv_stray && rom_q.size() == 0) begin
      rv_now = 1'b1;
      rd_now = $urandom;
    end else begin
      rv_now = 1'b0;
      rd_now = $urandom;
    end
    rom_if.instr_rvalid_i = rv_now;
    rom_if.instr_rdata_i  = rd_now;
    #1;
    live = 0;
    foreach (m_stale[i]) if (!m_stale[i]) live++;
    exp_valid = (m_fifo.size() > 0);
    exp_req   = drv_rst && drv_req && !drv_branch && (m_fifo.size() + live < DEPTH) && (m_infl.size() < MAXO);
    exp_iaddr = drv_rst ? m_fetch : BOOT;
    s_req   = rom_if.instr_req_o;
    s_iaddr = rom_if.instr_addr_o;
    s_valid = valid_o;
    s_addr  = addr_o;
    s_rdata = rdata_o;
    check("valid_o", 32'(s_valid), 32'(exp_valid));
    check("instr_req_o", 32'(s_req), 32'(exp_req));
    check("instr_addr_o", s_iaddr, exp_iaddr);
    if (exp_valid) begin
      check("addr_o", s_addr, m_fifo[0].addr);
      check("rdata_o", s_rdata, m_fifo[0].data);
    end
`ifdef PREFETCH_STATS_EN
    check("stat_fetched_o", stat_fetched_o, m_fetched);
    check("stat_discarded_o", stat_discarded_o, m_disc);
`endif
    @(posedge clk);
    if (rv_from_q) void'(rom_q.pop_front());
    if (s_req && drv_gnt) rom_q.push_back(s_iaddr);
    if (!drv_rst) begin
      model_reset();
    end else begin
      if (exp_valid && drv_ready && !drv_branch) void'(m_fifo.pop_front());
      if (rv_now && m_infl.size() > 0) begin
        a  = m_infl.pop_front();
        st = m_stale.pop_front();
        if (st || drv_branch) begin
          m_disc++;
        end else begin
          e.addr = a;
          e.data = rd_now;
          m_fifo.push_back(e);
          m_fetched++;
        end
      end
      if (drv_branch) begin
        m_disc += 32'(m_fifo.size());
        m_fifo.delete();
        foreach (m_stale[i]) m_stale[i] = 1'b1;
        m_fetch = drv_baddr & 32'hFFFF_FFFC;
      end else if (exp_req && drv_gnt) begin
        m_infl.push_back(m_fetch);
        m_stale.push_back(1'b0);
        m_fetch += 32'd4;
      end
    end
    drv_branch = 1'b0;
    drv_stray  = 1'b0;
  endtask

  task automatic do_reset();
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; ready_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    rom_if.instr_gnt_i = 1'b0; rom_if.instr_rvalid_i = 1'b0; rom_if.instr_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_rdata_o", rdata_o, 32'd0);
    check("rst_addr_o", addr_o, 32'd0);
    check("rst_instr_req_o", 32'(rom_if.instr_req_o), 32'd0);
    check("rst_instr_addr_o", rom_if.instr_addr_o, BOOT);
    model_reset();

    // Streaming with ready high: one word per cycle, first valid two cycles after the first request.
    drv_req = 1'b1; drv_ready = 1'b1; drv_gnt = 1'b1; drv_rv = 1'b1;
    step(); check("a0_req", 32'(s_req), 32'd1); check("a0_iaddr", s_iaddr, 32'h80);
    step(); check("a1_iaddr", s_iaddr, 32'h84);
    step(); check("a2_valid", 32'(s_valid), 32'd1); check("a2_addr", s_addr, 32'h80); check("a2_data", s_rdata, 32'h80);
    step(); check("a3_addr", s_addr, 32'h84); check("a3_iaddr", s_iaddr, 32'h8C);

    // Reset while the 0x8C response is on the bus, then a stray response right after release.
    do_reset();
    check("r_req_in_reset", 32'(s_req), 32'd0); check("r_iaddr_in_reset", s_iaddr, BOOT);
    drv_stray = 1'b1;
    step();
    check("r_valid", 32'(s_valid), 32'd0); check("r_addr_o", s_addr, 32'd0);
    check("r_rdata_o", s_rdata, 32'd0); check("r_restart", s_iaddr, 32'h80);
    step(); step();
    check("r_first_addr", s_addr, 32'h80); check("r_first_data", s_rdata, 32'h80);

    // Core stalls: FIFO fills to DEPTH, requests stop, then drains in order.
    drv_ready = 1'b0;
    do_reset();
    repeat (10) step();
    check("b_req_stalled", 32'(s_req), 32'd0); check("b_valid", 32'(s_valid), 32'd1);
    drv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("b_drain_addr", s_addr, 32'h80 + 32'(4 * i));
    end

    // Branch with two responses in flight and a head entry offered to the core.
    drv_ready = 1'b0; drv_rv = 1'b1;
    do_reset();
    step(); step();
    drv_rv = 1'b0;
    step();
    drv_branch = 1'b1; drv_baddr = 32'h203; drv_ready = 1'b1;
    step();
    check("c_valid_at_branch", 32'(s_valid), 32'd1); check("c_no_req_at_branch", 32'(s_req), 32'd0);
    step();
    check("c_flushed", 32'(s_valid), 32'd0);
    check("c_state_flush", 32'(dut.state_q), 32'(FLUSH));
    drv_rv = 1'b1;
    begin
      int k = 0;
      do begin step(); k++; end while (!s_valid && k < 20);
    end
    check("c_target_seen", 32'(s_valid), 32'd1);
    check("c_target_addr", s_addr, 32'h200); check("c_target_data", s_rdata, 32'h200);
`ifdef PREFETCH_STATS_EN
    check("c_stat_disc_ge2", 32'(stat_discarded_o >= 32'd2), 32'd1);
`endif

    // Address wrap at the top of the space, branch with nothing in flight.
    drv_req = 1'b0;
    repeat (5) step();
    drv_req = 1'b1; drv_branch = 1'b1; drv_baddr = 32'hFFFF_FFFF;
    step(); check("d_no_req_at_branch", 32'(s_req), 32'd0);
    step(); check("d_req_b1", 32'(s_req), 32'd1); check("d_iaddr_top", s_iaddr, 32'hFFFF_FFFC);
    step(); check("d_iaddr_wrap", s_iaddr, 32'h0);
    step(); check("d_target_b3", s_addr, 32'hFFFF_FFFC);

    // Randomised traffic against the model.
    rom_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      drv_rst    = ($urandom_range(0, 199) != 0);
      drv_req    = ($urandom_range(0, 9) != 0);
      drv_ready  = ($urandom_range(0, 3) != 0);
      drv_branch = ($urandom_range(0, 19) == 0);
      drv_baddr  = $urandom;
      drv_gnt    = ($urandom_range(0, 3) != 0);
      drv_rv     = ($urandom_range(0, 3) != 0);
      drv_stray  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
